reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Upstream stage that produces clean, ordered per-stage resets and enables for downstream blocks.
- Downstream blocks share one clock. Without ordering, several always blocks would react to the same first clock edge in an undefined order.
- The block synchronises reset deassertion and stretches it. It then releases NUM_STAGES downstream stages one at a time, in fixed index order, so no two stages leave reset on the same edge.

Parameters:
- NUM_STAGES, 2, number of downstream stages sequenced (legal 1..8).
- SYNC_STAGES, 2, reset-deassert synchroniser depth (legal >= 2).
- STRETCH, 4, cycles held after synchronised deassert before the first release (legal >= 1).
- GAP, 2, cycles between consecutive stage releases, and from the last release to seq_done (legal >= 1).

Ports:
- clock  input  1  sole clock; all state advances on posedge clock.
- reset  input  1  asynchronous, active-high reset.
- ext_hold  input  1  synchronous; freezes the sequence counters while high.
- stage_rst  output  NUM_STAGES  active-high per-stage reset; bit i drives stage i.
- stage_en  output  NUM_STAGES  per-stage enable.
- seq_done  output  1  high once all stages are released.

Behaviour:
- Interface: one clock, named clock. Reset is asynchronous and active-high, port reset.
- Reset asserted (asynchronous, immediate, including mid-sequence):
  - stage_rst = all ones; stage_en = 0; seq_done = 0.
  - Synchroniser chain set to all ones; FSM = SYNC; counters = 0.
- Edge numbering: edge 1 is the first posedge clock with reset low.
- SYNC: the chain shifts in 0. The internal sync reset deasserts at edge SYNC_STAGES. FSM moves to STRETCH on that edge.
- STRETCH:
  - Counter increments each edge where ext_hold is sampled low; it holds where ext_hold is sampled high.
  - At count STRETCH: stage_rst[0] clears and FSM moves to GAP with idx = 0.
  - No holds: stage_rst[0] clears at edge T0 = SYNC_STAGES + STRETCH + 1.
- stage_en[i] sets exactly one edge after stage_rst[i] clears. stage_en[i] is never high while stage_rst[i] is high.
- GAP:
  - Counts GAP non-held edges.
  - If idx < NUM_STAGES-1: clear stage_rst[idx+1], idx increments.
  - Otherwise: seq_done is set and FSM moves to DONE.
- Release and done times, no holds:
  - Stage i releases at T0 + i*GAP.
  - seq_done sets at T0 + NUM_STAGES*GAP.
- DONE: terminal. Outputs are static, ext_hold is ignored. Only reset leaves DONE.
- ext_hold:
  - Ignored in SYNC; the synchroniser always runs.
  - Each held edge in STRETCH or GAP delays all later events by exactly one edge.
  - Already-released stages stay released while held.
- All outputs come straight from flops; no combinational path from inputs to outputs.
- Counter width = $clog2(max(STRETCH, GAP) + 1).
- NUM_STAGES = 1: stage 0 releases at T0; seq_done sets at T0 + GAP.

Optional Feature:
- Macro: RESET_SEQ_XCHECK_EN. Simulation-only checker.
- Defined:
  - $error, with time, on any clock transition from x/z to 1.
  - $error at any posedge clock where reset or ext_hold is x/z.
  - Flop behaviour is unchanged.
- Undefined: no checker code is compiled and no messages are produced.

Test Plan:
- Defaults, reset high at t=0, released before edge 1, ext_hold = 0 -> stage_rst = 2'b11 until edge 7; stage_rst[0] = 0 at edge 7; stage_en[0] = 1 at edge 8; stage_rst[1] = 0 at edge 9; stage_en[1] = 1 at edge 10; seq_done = 1 at edge 11.
- Defaults, ext_hold high at edges 4 and 5 -> every event shifts by 2: releases at edges 9 and 11, seq_done at 13.
- Reset reasserted between edges 9 and 10 -> outputs return immediately to 2'b11 / 0 / 0; after release, the full sequence repeats from edge 1.
- NUM_STAGES=4, GAP=1, STRETCH=1 -> releases at edges 4, 5, 6, 7; seq_done at 8; never two bits of stage_rst clearing on the same edge.
- ext_hold toggling after seq_done -> outputs unchanged: stage_rst = 0, stage_en = all ones.
- RESET_SEQ_XCHECK_EN defined, clock left x then driven 1 -> exactly one $error logged; same stimulus with the macro undefined -> no message.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises and stretches reset deassertion, then releases
// NUM_STAGES downstream stages one per release slot. Optional macro: RESET_SEQ_XCHECK_EN.
module reset_sequencer #(
    parameter int NUM_STAGES  = 2,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 4,
    parameter int GAP         = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ext_hold,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  seq_done
);

    localparam int MAX_CNT = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [1:0] {
        S_SYNC,
        S_STRETCH,
        S_GAP,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   stage_rst_d;
    logic                    seq_done_d;
    logic [SYNC_STAGES-1:0]  sync_p0;
    logic                    sync_falling;

    // Synchroniser: shifts in zeros; the top bit is the internal synchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= '1;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], 1'b0};
        end
    end

    // The internal reset is still high but falls on this edge
    assign sync_falling = sync_p0[SYNC_STAGES-1] && !sync_p0[SYNC_STAGES-2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_SYNC;
            cnt_q     <= '0;
            idx_q     <= '0;
            stage_rst <= '1;
            stage_en  <= '0;
            seq_done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            stage_rst <= stage_rst_d;
            stage_en  <= ~stage_rst;
            seq_done  <= seq_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stage_rst_d = stage_rst;
        seq_done_d  = seq_done;

        case (state_q)
            S_SYNC: begin
                if (sync_falling) begin
                    state_d = S_STRETCH;
                    cnt_d   = '0;
                end
            end
            S_STRETCH: begin
                if (!ext_hold) begin
                    if (cnt_q == CNT_W'(STRETCH)) begin
                        stage_rst_d[0] = 1'b0;
                        cnt_d          = '0;
                        idx_d          = '0;
                        state_d        = S_GAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (!ext_hold) begin
                    if (cnt_q == CNT_W'(GAP - 1)) begin
                        cnt_d = '0;
                        if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                            seq_done_d = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            for (int i = 1; i < NUM_STAGES; i++) begin
                                if (int'(idx_q) + 1 == i) begin
                                    stage_rst_d[i] = 1'b0;
                                end
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_DONE;
            end
        endcase
    end

`ifdef RESET_SEQ_XCHECK_EN
    // Simulation-only: flag clocks rising out of an unknown level and unknown control inputs
    logic clock_last;

    always @(clock) begin
        if (clock === 1'b1 && $isunknown(clock_last)) begin
            $error("reset_sequencer: clock rose from x/z at time %0t", $time);
        end
        clock_last = clock;
    end

    always @(posedge clock) begin
        if ($isunknown({reset, ext_hold})) begin
            $error("reset_sequencer: reset or ext_hold unknown at time %0t", $time);
        end
    end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default build and a 4-stage/GAP=1/STRETCH=1 build,
// compared each edge against an event-time model driven by random ext_hold.
module tb_reset_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       ext_hold;
    logic [1:0] a_rst, a_en;
    logic       a_done;
    logic [3:0] b_rst, b_en;
    logic       b_done;

    reset_sequencer dut_a (
        .clock(clock), .reset(reset), .ext_hold(ext_hold),
        .stage_rst(a_rst), .stage_en(a_en), .seq_done(a_done)
    );

    reset_sequencer #(.NUM_STAGES(4), .SYNC_STAGES(2), .STRETCH(1), .GAP(1)) dut_b (
        .clock(clock), .reset(reset), .ext_hold(ext_hold),
        .stage_rst(b_rst), .stage_en(b_en), .seq_done(b_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: progress = number of non-held edges after the synchroniser finished.
    // Stage i leaves reset once progress reaches STRETCH+1+i*GAP; done at STRETCH+1+N*GAP.
    int         edge_n;
    int         pa, pb;
    int         fd_a, fd_b;
    logic [7:0] ra, ea, rb, eb;
    logic       da, db;
    logic [3:0] prev_b_rst;

    function automatic logic [7:0] exp_rst(input int p, input int n, input int st, input int g);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = (p < st + 1 + i * g);
        return r;
    endfunction

    function automatic logic exp_done(input int p, input int n, input int st, input int g);
        return p >= st + 1 + n * g;
    endfunction

    task automatic model_reset();
        edge_n = 0; pa = 0; pb = 0; fd_a = 0; fd_b = 0;
        ra = 8'h03; rb = 8'h0F; ea = '0; eb = '0; da = 1'b0; db = 1'b0;
        prev_b_rst = 4'hF;
    endtask

    task automatic model_edge(input logic h);
        edge_n++;
        if (edge_n > 2 && !h) begin
            pa++;
            pb++;
        end
        ea = ~ra & 8'h03;
        eb = ~rb & 8'h0F;
        ra = exp_rst(pa, 2, 4, 2);
        rb = exp_rst(pb, 4, 1, 1);
        da = exp_done(pa, 2, 4, 2);
        db = exp_done(pb, 4, 1, 1);
    endtask

    task automatic check_all();
        logic [3:0] cleared;
        check_eq("a_rst", a_rst, ra[1:0]);
        check_eq("a_en", a_en, ea[1:0]);
        check_eq("a_done", a_done, da);
        check_eq("b_rst", b_rst, rb[3:0]);
        check_eq("b_en", b_en, eb[3:0]);
        check_eq("b_done", b_done, db);
        check_eq("b_en_while_rst", b_en & b_rst, 0);
        cleared = prev_b_rst & ~b_rst;
        check_eq("b_single_release", ($countones(cleared) <= 1), 1);
        prev_b_rst = b_rst;
        if (a_done && fd_a == 0) fd_a = edge_n;
        if (b_done && fd_b == 0) fd_b = edge_n;
    endtask

    task automatic step(input logic h);
        ext_hold = h;
        @(posedge clock);
        model_edge(h);
        @(negedge clock);
        check_all();
    endtask

    // Asynchronous reset between edges, checked before any clock edge arrives
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_eq("async_a_rst", a_rst, 2'b11);
        check_eq("async_a_en", a_en, 0);
        check_eq("async_a_done", a_done, 0);
        check_eq("async_b_rst", b_rst, 4'hF);
        @(negedge clock);
        @(negedge clock);
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ext_hold = 1'b0;
        @(negedge clock);
        model_reset();
        check_all();
        @(negedge clock);
        reset = 1'b0;

        // Plain sequence
        for (int e = 1; e <= 16; e++) step(1'b0);
        check_eq("plain_a_done_edge", fd_a, 11);
        check_eq("plain_b_done_edge", fd_b, 8);

        // Holds at edges 4 and 5 shift every event by two
        async_reset();
        for (int e = 1; e <= 18; e++) step(e == 4 || e == 5);
        check_eq("hold_a_done_edge", fd_a, 13);

        // Reset reasserted between edges 9 and 10, then full repeat
        async_reset();
        for (int e = 1; e <= 9; e++) step(1'b0);
        async_reset();
        for (int e = 1; e <= 14; e++) step(1'b0);
        check_eq("repeat_a_done_edge", fd_a, 11);

        // ext_hold toggling after done leaves outputs static
        for (int e = 1; e <= 6; e++) step(e[0]);
        check_eq("post_done_a_rst", a_rst, 2'b00);
        check_eq("post_done_a_en", a_en, 2'b11);
        check_eq("post_done_b_en", b_en, 4'hF);

        // Random hold patterns, including holds across the done edge
        for (int run = 0; run < 20; run++) begin
            async_reset();
            for (int e = 1; e <= 30; e++) step($urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
